// File: rtl/data_ram_ctrl.sv
// Purpose : word-organised, byte-enabled data RAM behind the MEM-stage request port.
// Latency : request answered WAIT_STATES+2 cycles after first sight of ce_i (DONE cycle).
// Backpr. : stall_o freezes the requester from its first cycle until the DONE cycle.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ce_i, we_i        request valid, 1 = write / 0 = read
//   addr_i            byte address (bits [1:0] ignored)
//   sel_i             byte enables, sel_i[3] = data[31:24] (big-endian lanes)
//   data_i            lane-aligned write data
//   data_o            last read word (registered)
//   stall_o           combinational stall request to the control unit
//   err_o             one-cycle pulse in DONE of an out-of-range access
module data_ram_ctrl #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        stall_o,
   output logic        err_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic [3:0] cnt;

   logic [31:0] mem [2**ADDR_W];

   logic [ADDR_W-1:0] word_idx;
   logic              out_of_range;
   logic              do_access;

   assign word_idx     = addr_i[ADDR_W+1:2];
   assign out_of_range = |addr_i[31:ADDR_W+2];
   // The RAM operation happens on the edge that leaves ACCESS.
   assign do_access    = (state == ACCESS) && (cnt == 4'd0);

   // Sub-word address bits carry no meaning for a word RAM.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^addr_i[1:0];

   // Next state and stall. Stall is combinational so the request is held
   // from the very cycle it first appears.
   always_comb begin
      state_nxt = state;
      stall_o   = 1'b0;
      case (state)
         IDLE: begin
            if (ce_i) begin
               stall_o   = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            stall_o = 1'b1;
            if (cnt == 4'd0) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         data_o <= 32'd0;
         err_o  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && ce_i) begin
            cnt <= 4'(WAIT_STATES);
         end else if (state == ACCESS && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         // Registered one cycle after the access edge, so high only in DONE.
         err_o <= do_access && out_of_range;
         if (do_access && !we_i) begin
            data_o <= out_of_range ? 32'd0 : mem[word_idx];
         end
      end
   end

   // RAM array has no reset. The rst term keeps a reset that lands on the
   // access edge from committing a half-finished write.
   always_ff @(posedge clk) begin
      if (do_access && we_i && !out_of_range && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (sel_i[b]) begin
               mem[word_idx][b*8 +: 8] <= data_i[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Purpose : directed self-checking bench for data_ram_ctrl (WAIT_STATES=1, ADDR_W=10).
// Latency : each request expected to stall 3 cycles, results checked in DONE.
// Backpr. : requests held stable while stall_o is high.
module tb_data_ram_ctrl;

   logic        clk;
   logic        rst;
   logic        ce_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [3:0]  sel_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        stall_o;
   logic        err_o;

   int total;
   int bad;

   data_ram_ctrl #(
      .ADDR_W      (10),
      .WAIT_STATES (1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ce_i    (ce_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .sel_i   (sel_i),
      .data_i  (data_i),
      .data_o  (data_o),
      .stall_o (stall_o),
      .err_o   (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Called just after a negedge. Returns the number of stalled cycles and the
   // data/err seen in the first non-stalled (DONE) cycle. Leaves the bench
   // at the negedge of the cycle after DONE. keep=1 leaves ce_i asserted.
   task automatic req(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic keep,
                      output int stalls, output logic [31:0] rd, output logic er);
      logic done;
      ce_i   = 1'b1;
      we_i   = w;
      addr_i = a;
      sel_i  = s;
      data_i = d;
      stalls = 0;
      done   = 1'b0;
      rd     = 32'hx;
      er     = 1'bx;
      for (int i = 0; i < 40 && !done; i++) begin
         #1;
         if (!stall_o) begin
            done = 1'b1;
            rd   = data_o;
            er   = err_o;
         end else begin
            stalls++;
            @(negedge clk);
         end
      end
      if (!done) begin
         chk("req_timeout", 32'(stalls), 32'd0);
      end
      if (!keep) ce_i = 1'b0;
      @(negedge clk);
   endtask

   int          st;
   logic [31:0] rd;
   logic        er;

   initial begin
      total  = 0;
      bad    = 0;
      rst    = 1'b1;
      ce_i   = 1'b0;
      we_i   = 1'b0;
      addr_i = 32'd0;
      sel_i  = 4'd0;
      data_i = 32'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_data", data_o, 32'd0);
      chk("reset_stall", 32'(stall_o), 32'd0);
      chk("reset_err", 32'(err_o), 32'd0);
      @(negedge clk);

      // Full word write then read
      req(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0, st, rd, er);
      chk("wr_full_stalls", 32'(st), 32'd3);
      chk("wr_full_err", 32'(er), 32'd0);
      chk("wr_keeps_data_o", rd, 32'd0);
      req(1'b0, 32'h10, 4'b0000, 32'd0, 1'b0, st, rd, er);
      chk("rd_full_stalls", 32'(st), 32'd3);
      chk("rd_full_data", rd, 32'hDEADBEEF);
      chk("rd_full_err", 32'(er), 32'd0);

      // Single byte, lane 2 (data[23:16])
      req(1'b1, 32'h10, 4'b0100, 32'h00AB0000, 1'b0, st, rd, er);
      req(1'b0, 32'h10, 4'b1111, 32'd0, 1'b0, st, rd, er);
      chk("rd_byte", rd, 32'hDEABBEEF);

      // Low half write; data_o must still hold the previous read
      req(1'b1, 32'h10, 4'b0011, 32'h00001234, 1'b0, st, rd, er);
      chk("wr_half_data_o_held", rd, 32'hDEABBEEF);
      req(1'b0, 32'h10, 4'b0000, 32'd0, 1'b0, st, rd, er);
      chk("rd_half", rd, 32'hDEAB1234);

      // No-op write with zero enables, low address bits ignored
      req(1'b1, 32'h13, 4'b0000, 32'hFFFFFFFF, 1'b0, st, rd, er);
      req(1'b0, 32'h12, 4'b0000, 32'd0, 1'b0, st, rd, er);
      chk("rd_sel0_noop", rd, 32'hDEAB1234);

      // Out of range accesses
      req(1'b1, 32'h0, 4'b1111, 32'hCAFEF00D, 1'b0, st, rd, er);
      req(1'b0, 32'h1000, 4'b1111, 32'd0, 1'b0, st, rd, er);
      chk("oor_rd_data", rd, 32'd0);
      chk("oor_rd_err", 32'(er), 32'd1);
      #1;
      chk("oor_err_one_cycle", 32'(err_o), 32'd0);
      req(1'b1, 32'h1000, 4'b1111, 32'h12345678, 1'b0, st, rd, er);
      chk("oor_wr_err", 32'(er), 32'd1);
      req(1'b0, 32'h0, 4'b1111, 32'd0, 1'b0, st, rd, er);
      chk("oor_wr_dropped", rd, 32'hCAFEF00D);
      chk("inrange_err", 32'(er), 32'd0);

      // Reset in the middle of a write
      req(1'b1, 32'h20, 4'b1111, 32'h55AA55AA, 1'b0, st, rd, er);
      req(1'b0, 32'h20, 4'b1111, 32'd0, 1'b0, st, rd, er);
      chk("rst_pre_read", rd, 32'h55AA55AA);
      ce_i   = 1'b1;
      we_i   = 1'b1;
      addr_i = 32'h20;
      sel_i  = 4'b1111;
      data_i = 32'h11111111;
      @(negedge clk);            // now in ACCESS, cnt = 1
      #1;
      chk("rst_in_access_stall", 32'(stall_o), 32'd1);
      rst  = 1'b1;
      ce_i = 1'b0;
      #1;
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_data", data_o, 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      req(1'b0, 32'h20, 4'b1111, 32'd0, 1'b0, st, rd, er);
      chk("rst_no_write", rd, 32'h55AA55AA);

      // Back-to-back reads with ce_i held through DONE
      req(1'b0, 32'h10, 4'b1111, 32'd0, 1'b1, st, rd, er);
      chk("b2b_first_stalls", 32'(st), 32'd3);
      chk("b2b_first_data", rd, 32'hDEAB1234);
      req(1'b0, 32'h0, 4'b1111, 32'd0, 1'b0, st, rd, er);
      chk("b2b_second_stalls", 32'(st), 32'd3);
      chk("b2b_second_data", rd, 32'hCAFEF00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global guard so the run always terminates.
   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
